// File: rtl/fb_rect_writer.sv
// ============================================================================
// Module   : fb_rect_writer
// Brief    : Clipped rectangle fill into the 320x240 scan-out frame buffer RAM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fb_rect_writer #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               wr_allow,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_din,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pix_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [9:0]        c_fb_w10  = 10'(FB_W);
    localparam logic [9:0]        c_fb_h10  = 10'(FB_H);
    localparam logic [ADDR_W-1:0] c_fb_w_a  = ADDR_W'(FB_W);

    state_t               state_q, state_d;
    logic [8:0]           x0_q, x0_d;
    logic [7:0]           y0_q, y0_d;
    logic [8:0]           w_q, w_d;
    logic [7:0]           h_q, h_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [9:0]           w_eff_q, w_eff_d;
    logic [9:0]           h_eff_q, h_eff_d;
    logic [9:0]           col_q, col_d;
    logic [9:0]           row_q, row_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0]   mem_din_q, mem_din_d;
    logic [ADDR_W-1:0]    pix_count_q, pix_count_d;
    logic                 done_q, done_d;

    logic [9:0]           w_rem, h_rem, w_clip, h_clip;
    logic                 cmd_empty;
    logic [ADDR_W-1:0]    x0_ext, y0_ext, col_ext;
    logic                 col_last, row_last;

    // Clip in 10 bits; the remainders are only meaningful when the origin is in-frame.
    assign w_rem     = c_fb_w10 - {1'b0, x0_q};
    assign h_rem     = c_fb_h10 - {2'b00, y0_q};
    assign w_clip    = ({1'b0, w_q} < w_rem) ? {1'b0, w_q} : w_rem;
    assign h_clip    = ({2'b00, h_q} < h_rem) ? {2'b00, h_q} : h_rem;
    assign cmd_empty = ({1'b0, x0_q} >= c_fb_w10) || ({2'b00, y0_q} >= c_fb_h10)
                     || (w_q == 9'd0) || (h_q == 8'd0);

    assign x0_ext   = {{(ADDR_W-9){1'b0}}, x0_q};
    assign y0_ext   = {{(ADDR_W-8){1'b0}}, y0_q};
    assign col_ext  = {{(ADDR_W-10){1'b0}}, col_q};
    assign col_last = (col_q == w_eff_q - 10'd1);
    assign row_last = (row_q == h_eff_q - 10'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            w_eff_q     <= '0;
            h_eff_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            pix_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            w_eff_q     <= w_eff_d;
            h_eff_q     <= h_eff_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            pix_count_q <= pix_count_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        w_eff_d     = w_eff_q;
        h_eff_d     = h_eff_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        pix_count_d = pix_count_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x0_d        = cmd_x0;
                    y0_d        = cmd_y0;
                    w_d         = cmd_w;
                    h_d         = cmd_h;
                    color_d     = cmd_color;
                    pix_count_d = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                w_eff_d    = w_clip;
                h_eff_d    = h_clip;
                col_d      = '0;
                row_d      = '0;
                row_base_d = (y0_ext << 8) + (y0_ext << 6);
                if (cmd_empty) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (wr_allow) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = row_base_q + x0_ext + col_ext;
                    mem_din_d   = color_q;
                    pix_count_d = pix_count_q + 1'b1;
                    if (col_last) begin
                        col_d      = '0;
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + c_fb_w_a;
                        if (row_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            S_DONE: begin
                // After a fill the last write is still on the port here, so done follows a cycle later.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign pix_count = pix_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
// ============================================================================
// Module   : tb_fb_rect_writer
// Brief    : Self-checking bench for fb_rect_writer against a clipped-rectangle model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fb_rect_writer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x0;
    logic [7:0]  cmd_y0;
    logic [8:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        wr_allow;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_din;
    logic        busy;
    logic        done;
    logic [16:0] pix_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    logic stall_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic [8:0]  x0;
        logic [7:0]  y0;
        logic [8:0]  w;
        logic [7:0]  h;
        logic [11:0] color;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    fb_rect_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_allow  (wr_allow),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: every in-frame pixel of the rectangle, raster order.
    function automatic void build_exp(input int x0, input int y0, input int w, input int h);
        exp_q.delete();
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < 320 && y < 240) exp_q.push_back(x + 320 * y);
    endfunction

    // mode 0: wr_allow always 1; 1: random; 2: stall pattern; 3: intruding command while busy
    task automatic run_cmd(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                           input logic [7:0] h, input logic [11:0] col, input int mode,
                           output int nw, output int first_a, output int last_a);
        int s, rem, total, budget, k, first_s, last_s, done_s, done_n, expa;
        logic allow, allow_prev;
        build_exp(int'(x0), int'(y0), int'(w), int'(h));
        total = exp_q.size();
        rem = total;
        budget = 4 * total + 30;
        nw = 0; first_a = -1; last_a = -1; k = 0;
        first_s = -1; last_s = -1; done_s = -1; done_n = 0;
        chk("ready_in_idle", cmd_ready, 1);
        cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col;
        cmd_valid = 1'b1;
        wr_allow = 1'b1;
        allow_prev = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        s = 0;
        chk("accept_busy", busy, 1);
        chk("accept_not_ready", cmd_ready, 0);
        while (1) begin
            if (s >= 2) chk("we_cycle", mem_we, (rem > 0 && allow_prev) ? 1 : 0);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    expa = exp_q.pop_front();
                    chk("addr", mem_addr, expa);
                end
                chk("din", mem_din, col);
                chk("addr_in_frame", (mem_addr < 17'd76800) ? 1 : 0, 1);
                if (first_a < 0) begin
                    first_a = int'(mem_addr);
                    first_s = s;
                end
                last_a = int'(mem_addr);
                last_s = s;
                nw++;
                rem--;
            end else if (nw > 0 && busy) begin
                chk("addr_hold", mem_addr, last_a);
                chk("din_hold", mem_din, col);
            end
            if (done) begin
                done_n++;
                if (done_s < 0) done_s = s;
            end
            if (!busy) break;
            if (s > budget) begin
                chk("timeout", 0, 1);
                break;
            end
            if (mode == 3 && s == 3) begin
                cmd_x0 = 9'd100; cmd_y0 = 8'd100; cmd_w = 9'd5; cmd_h = 8'd5;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (mode == 1) begin
                allow = ($urandom_range(0, 9) < 7);
            end else if (mode == 2 && s >= 1) begin
                allow = (k < 7) ? stall_pat[k] : 1'b1;
                k++;
            end else begin
                allow = 1'b1;
            end
            wr_allow = allow;
            allow_prev = allow;
            @(posedge clk); #1;
            s++;
        end
        cmd_valid = 1'b0;
        wr_allow = 1'b1;
        chk("missing_writes", exp_q.size(), 0);
        chk("pix_count", pix_count, total);
        chk("done_pulses", done_n, 1);
        if (total == 0) chk("done_lat_empty", done_s, 1);
        else chk("done_after_last", done_s, last_s + 1);
        if (total > 0 && mode == 0) begin
            chk("first_write_lat", first_s, 2);
            chk("contiguous", last_s - first_s, total - 1);
        end
    endtask

    initial begin
        vec_t vecs[11];
        int nw, fa, la, cnt;
        int bad;

        vecs[0]  = '{9'd0,   8'd0,   9'd2,   8'd2,   12'hF00, 4,   0,     321};
        vecs[1]  = '{9'd318, 8'd239, 9'd5,   8'd3,   12'h0F0, 2,   76798, 76799};
        vecs[2]  = '{9'd5,   8'd5,   9'd0,   8'd3,   12'h00F, 0,   0,     0};
        vecs[3]  = '{9'd320, 8'd0,   9'd4,   8'd4,   12'h123, 0,   0,     0};
        vecs[4]  = '{9'd0,   8'd240, 9'd4,   8'd4,   12'h456, 0,   0,     0};
        vecs[5]  = '{9'd7,   8'd7,   9'd3,   8'd0,   12'h789, 0,   0,     0};
        vecs[6]  = '{9'd0,   8'd10,  9'd320, 8'd1,   12'hABC, 320, 3200,  3519};
        vecs[7]  = '{9'd319, 8'd239, 9'd1,   8'd1,   12'hFFF, 1,   76799, 76799};
        vecs[8]  = '{9'd300, 8'd0,   9'd511, 8'd2,   12'h0AA, 40,  300,   639};
        vecs[9]  = '{9'd0,   8'd200, 9'd2,   8'd255, 12'h555, 80,  64000, 76481};
        vecs[10] = '{9'd511, 8'd0,   9'd8,   8'd8,   12'h321, 0,   0,     0};

        rst = 1'b1; cmd_valid = 1'b1; wr_allow = 1'b1;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = 9'd4; cmd_h = 8'd4; cmd_color = 12'hFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_pix", pix_count, 0);
        rst = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 0, nw, fa, la);
            chk("tbl_count", nw, vecs[i].exp_n);
            if (vecs[i].exp_n > 0) begin
                chk("tbl_first", fa, vecs[i].exp_first);
                chk("tbl_last", la, vecs[i].exp_last);
            end
        end

        run_cmd(9'd10, 8'd5, 9'd4, 8'd1, 12'h0C3, 2, nw, fa, la);
        chk("stall_count", nw, 4);
        chk("stall_first", fa, 1610);
        chk("stall_last", la, 1613);

        run_cmd(9'd20, 8'd20, 9'd3, 8'd2, 12'h3C0, 3, nw, fa, la);
        chk("intrude_count", nw, 6);
        run_cmd(9'd50, 8'd1, 9'd2, 8'd1, 12'h0FF, 0, nw, fa, la);
        chk("b2b_first", fa, 370);

        for (int i = 0; i < 30; i++) begin
            run_cmd(9'($urandom_range(0, 340)), 8'($urandom_range(0, 255)),
                    9'($urandom_range(0, 30)), 8'($urandom_range(0, 16)),
                    12'($urandom), 1, nw, fa, la);
        end

        cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'd320; cmd_h = 8'd240; cmd_color = 12'h777;
        cmd_valid = 1'b1; wr_allow = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (mem_we) cnt++;
            if (cnt == 100) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_writes", cnt, 100);
        chk("pre_rst_pix", pix_count, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_pix", pix_count, 0);
        chk("midrst_done", done, 0);
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || mem_we || busy) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
